// File: rtl/adc_capture_sequencer.sv
// ADC burst capture sequencer: IDLE/CAPTURE/DRAIN/DONE FSM feeding a first-word fall-through frame FIFO.
// Define ADC_SEQ_OVERRUN_ABORT_EN to end the capture phase on the first dropped frame.
module adc_capture_sequencer #(
  parameter int DATA_W     = 24,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [CNT_W-1:0]  i_num_samples,
  output logic              o_read_enable,
  input  logic              i_data_ready,
  input  logic [DATA_W-1:0] i_data_frame,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun,
  output logic [CNT_W-1:0]  o_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, r_n, w_cnt_inc;
  logic              r_overrun;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_fill;
  logic              w_empty, w_full, w_pop, w_frame, w_push, w_drop, w_start_ok;

  assign w_empty    = (r_fill == '0);
  assign w_full     = (r_fill == FULL_CNT);
  assign w_pop      = !w_empty && i_ready;
  assign w_frame    = (r_state == S_CAPTURE) && i_data_ready;
  // a full FIFO still accepts a frame when the head leaves in the same cycle
  assign w_push     = w_frame && (!w_full || w_pop);
  assign w_drop     = w_frame && w_full && !w_pop;
  assign w_cnt_inc  = r_count + CNT_W'(1);
  assign w_start_ok = i_start && (i_num_samples != '0);

  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid   = !w_empty;
  assign o_count   = r_count;
  assign o_overrun = r_overrun;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data_frame;
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (AW+1)'(1);
        2'b01:   r_fill <= r_fill - (AW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_n       <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_start_ok) begin
        r_n       <= i_num_samples;
        r_count   <= '0;
        r_overrun <= 1'b0;
      end
      if (w_frame) r_count   <= w_cnt_inc;
      if (w_drop)  r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_read_enable = 1'b0;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_ok) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        o_read_enable = 1'b1;
        o_busy        = 1'b1;
`ifdef ADC_SEQ_OVERRUN_ABORT_EN
        if (i_stop || (i_data_ready && w_cnt_inc == r_n) || w_drop) w_state_nxt = S_DRAIN;
`else
        if (i_stop || (i_data_ready && w_cnt_inc == r_n)) w_state_nxt = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_empty) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: directed table, corner sequences, then random traffic against a queue model.
module tb_adc_capture_sequencer;
  localparam int DW = 24, CW = 16, D = 8;

  logic          clk = 1'b0, i_reset = 1'b1;
  logic          i_start = 0, i_stop = 0, i_data_ready = 0, i_ready = 0;
  logic [CW-1:0] i_num_samples = '0;
  logic [DW-1:0] i_data_frame = '0;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_count;
  logic          o_read_enable, o_valid, o_busy, o_done, o_overrun;

  adc_capture_sequencer #(.DATA_W(DW), .CNT_W(CW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_num_samples(i_num_samples), .o_read_enable(o_read_enable),
    .i_data_ready(i_data_ready), .i_data_frame(i_data_frame), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done),
    .o_overrun(o_overrun), .o_count(o_count));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  // reference model: phase 0 idle, 1 capture, 2 drain, 3 done
  int            m_st = 0;
  logic [DW-1:0] mq[$];
  logic [CW-1:0] m_cnt = '0, m_n = '0;
  logic          m_ovr = 0;

  typedef struct {
    logic start, stop; logic [CW-1:0] n; logic dr; logic [DW-1:0] fr; logic rdy;
    logic e_valid; logic [DW-1:0] e_data; logic [CW-1:0] e_count; logic e_busy, e_re, e_done;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_st = 0; m_cnt = '0; m_ovr = 0;
  endtask

  task automatic drive(input logic st, input logic sp, input logic [CW-1:0] n,
                       input logic dr, input logic [DW-1:0] fr, input logic rdy);
    logic pop, push, drop; int ns, sz;
    i_start = st; i_stop = sp; i_num_samples = n; i_data_ready = dr;
    i_data_frame = fr; i_ready = rdy;
    sz = mq.size(); pop = (sz > 0) && rdy; push = 0; drop = 0; ns = m_st;
    case (m_st)
      0: if (st && n != 0) begin m_n = n; m_cnt = '0; m_ovr = 0; ns = 1; end
      1: begin
        if (dr) begin
          m_cnt = m_cnt + 1'b1;
          if (sz < D || pop) push = 1; else begin drop = 1; m_ovr = 1; end
        end
        if (sp || (dr && m_cnt == m_n)) ns = 2;
`ifdef ADC_SEQ_OVERRUN_ABORT_EN
        if (drop) ns = 2;
`endif
      end
      2: if (sz == 0) ns = 3;
      default: ns = 0;
    endcase
    @(posedge clk); #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(fr);
    m_st = ns;
  endtask

  task automatic idle(input logic rdy);
    drive(0, 0, '0, 0, '0, rdy);
  endtask

  task automatic check_model();
    chk("valid", o_valid, mq.size() > 0);
    chk("data", o_data, mq.size() > 0 ? mq[0] : '0);
    chk("count", o_count, m_cnt);
    chk("overrun", o_overrun, m_ovr);
    chk("busy", o_busy, m_st == 1 || m_st == 2);
    chk("read_en", o_read_enable, m_st == 1);
    chk("done", o_done, m_st == 3);
  endtask

  function automatic vec_t mk(logic st, logic sp, logic [CW-1:0] n, logic dr, logic [DW-1:0] fr,
                              logic rdy, logic ev, logic [DW-1:0] ed, logic [CW-1:0] ec,
                              logic eb, logic er, logic edn);
    vec_t v;
    v.start = st; v.stop = sp; v.n = n; v.dr = dr; v.fr = fr; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_count = ec; v.e_busy = eb; v.e_re = er; v.e_done = edn;
    return v;
  endfunction

  initial begin
    int dones;
    // four-frame burst with a ready consumer, then a zero-length start
    tbl[0] = mk(1, 0, 4, 0, 0, 1,  0, 0, 0, 1, 1, 0);
    tbl[1] = mk(0, 0, 0, 1, 1, 1,  1, 1, 1, 1, 1, 0);
    tbl[2] = mk(0, 0, 0, 1, 2, 1,  1, 2, 2, 1, 1, 0);
    tbl[3] = mk(0, 0, 0, 1, 3, 1,  1, 3, 3, 1, 1, 0);
    tbl[4] = mk(0, 0, 0, 1, 4, 1,  1, 4, 4, 1, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 0, 1,  0, 0, 4, 1, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 1,  0, 0, 4, 0, 0, 1);
    tbl[7] = mk(0, 0, 0, 0, 0, 1,  0, 0, 4, 0, 0, 0);
    tbl[8] = mk(1, 0, 0, 1, 9, 1,  0, 0, 4, 0, 0, 0);

    #2;
    chk("rst_valid", o_valid, 0); chk("rst_busy", o_busy, 0); chk("rst_re", o_read_enable, 0);
    chk("rst_done", o_done, 0); chk("rst_ovr", o_overrun, 0); chk("rst_count", o_count, 0);
    chk("rst_data", o_data, 0);
    repeat (2) @(posedge clk);
    #1 i_reset = 0;
    model_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].start, tbl[i].stop, tbl[i].n, tbl[i].dr, tbl[i].fr, tbl[i].rdy);
      chk($sformatf("t%0d_valid", i), o_valid, tbl[i].e_valid);
      chk($sformatf("t%0d_data", i), o_data, tbl[i].e_data);
      chk($sformatf("t%0d_count", i), o_count, tbl[i].e_count);
      chk($sformatf("t%0d_busy", i), o_busy, tbl[i].e_busy);
      chk($sformatf("t%0d_re", i), o_read_enable, tbl[i].e_re);
      chk($sformatf("t%0d_done", i), o_done, tbl[i].e_done);
    end

    // overrun: N=12 into a depth-8 FIFO with a stalled consumer
    drive(1, 0, 12, 0, 0, 0); check_model();
    for (int k = 1; k <= 12; k++) begin
      drive(0, 0, 0, 1, DW'(k), 0); check_model();
`ifdef ADC_SEQ_OVERRUN_ABORT_EN
      if (k == 9) chk("abort_re", o_read_enable, 0);
`else
      if (k == 9) chk("cont_re", o_read_enable, 1);
`endif
    end
    chk("ovr_flag", o_overrun, 1);
    for (int j = 0; j < D; j++) begin
      chk("ovr_order", o_data, 32'(j + 1));
      idle(1); check_model();
    end
    idle(1); check_model(); idle(1); check_model();

    // full FIFO: push and pop in the same cycle is not an overrun
    drive(1, 0, 20, 0, 0, 0);
    for (int k = 0; k < D; k++) drive(0, 0, 0, 1, DW'(32'h100 + k), 0);
    drive(0, 0, 0, 1, 24'h1FF, 1);
    chk("full_pp_ovr", o_overrun, 0); chk("full_pp_head", o_data, 32'h101);
    check_model();
    drive(0, 1, 0, 0, 0, 0); check_model();
    for (int k = 0; k < 11; k++) begin idle(1); check_model(); end

    // stop after three frames of a long burst
    drive(1, 0, 100, 0, 0, 1);
    for (int k = 1; k <= 3; k++) drive(0, 0, 0, 1, DW'(32'h30 + k), 0);
    drive(0, 1, 0, 0, 0, 0);
    chk("stop_count", o_count, 3); chk("stop_re", o_read_enable, 0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin idle(1); check_model(); dones += int'(o_done); end
    chk("stop_dones", dones, 1);

    // asynchronous reset with frames buffered
    drive(1, 0, 10, 0, 0, 0);
    for (int k = 1; k <= 5; k++) drive(0, 0, 0, 1, DW'(k), 0);
    #2 i_reset = 1;
    #1;
    chk("arst_valid", o_valid, 0); chk("arst_busy", o_busy, 0);
    chk("arst_done", o_done, 0); chk("arst_data", o_data, 0);
    @(posedge clk); #1 i_reset = 0;
    model_reset();
    dones = 0;
    for (int k = 0; k < 4; k++) begin idle(1); check_model(); dones += int'(o_done); end
    chk("arst_nodone", dones, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
            CW'($urandom_range(0, 14)), $urandom_range(0, 1) == 1,
            DW'($urandom), $urandom_range(0, 3) != 0);
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
